// File: rtl/regfile_scoreboard.sv
// Register file with two read ports, two prioritised write ports, optional
// write-to-read forwarding and a per-register busy scoreboard for hazard checks.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic              reg_write0,
  input  logic [ADDR_W-1:0] write_reg0,
  input  logic [DATA_W-1:0] write_data0,
  input  logic              reg_write1,
  input  logic [ADDR_W-1:0] write_reg1,
  input  logic [DATA_W-1:0] write_data1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic [ADDR_W:0]   busy_count,
  output logic              err_double_rsv
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic [NUM_REGS-1:0] wr0_hit, wr1_hit, rsv_hit;
  logic [ADDR_W:0]     busy_count_reg, busy_count_next;
  logic                err_reg, err_next;
  logic                rsv_wr_same;

  // Per-register decode; register 0 never matches so it stays zero and idle.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      assign wr0_hit[gi] = reg_write0 && (write_reg0 == ADDR_W'(gi)) && (gi != 0);
      assign wr1_hit[gi] = reg_write1 && (write_reg1 == ADDR_W'(gi)) && (gi != 0);
      assign rsv_hit[gi] = rsv_en && (rsv_reg == ADDR_W'(gi)) && (gi != 0);
      // A reservation outranks a same-cycle writeback to the same register.
      assign busy_next[gi] = rsv_hit[gi] | (busy_reg[gi] & ~(wr0_hit[gi] | wr1_hit[gi]));
    end
  endgenerate

  assign rsv_wr_same = (reg_write0 && (write_reg0 == rsv_reg)) ||
                       (reg_write1 && (write_reg1 == rsv_reg));

  always_comb begin
    err_next = err_reg;
    if (rsv_en && (rsv_reg != '0) && busy_reg[rsv_reg] && !rsv_wr_same)
      err_next = 1'b1;
  end

  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_count_next = busy_count_next + (ADDR_W + 1)'(busy_next[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      busy_reg       <= '0;
      busy_count_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr0_hit[i])      regs_reg[i] <= write_data0;
        else if (wr1_hit[i]) regs_reg[i] <= write_data1;
      end
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
      err_reg        <= err_next;
    end
  end

  // Forwarding follows the same port-0-first priority as the stored write.
  always_comb begin
    read_data1 = '0;
    if (read_reg1 != '0) begin
      if ((BYPASS != 0) && reg_write0 && (write_reg0 == read_reg1))      read_data1 = write_data0;
      else if ((BYPASS != 0) && reg_write1 && (write_reg1 == read_reg1)) read_data1 = write_data1;
      else                                                               read_data1 = regs_reg[read_reg1];
    end
  end

  always_comb begin
    read_data2 = '0;
    if (read_reg2 != '0) begin
      if ((BYPASS != 0) && reg_write0 && (write_reg0 == read_reg2))      read_data2 = write_data0;
      else if ((BYPASS != 0) && reg_write1 && (write_reg1 == read_reg2)) read_data2 = write_data1;
      else                                                               read_data2 = regs_reg[read_reg2];
    end
  end

  assign read_busy1     = busy_reg[read_reg1];
  assign read_busy2     = busy_reg[read_reg2];
  assign busy_count     = busy_count_reg;
  assign err_double_rsv = err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic compared against an array-based model of the register file rules.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg0, write_reg1, rsv_reg;
  logic [31:0] read_data1, read_data2, write_data0, write_data1;
  logic        read_busy1, read_busy2, reg_write0, reg_write1, rsv_en;
  logic [5:0]  busy_count;
  logic        err_double_rsv;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_err;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .read_busy1(read_busy1), .read_busy2(read_busy2),
    .reg_write0(reg_write0), .write_reg0(write_reg0), .write_data0(write_data0),
    .reg_write1(reg_write1), .write_reg1(write_reg1), .write_data1(write_data1),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .busy_count(busy_count), .err_double_rsv(err_double_rsv)
  );

  always #5 clk = ~clk;

  // Reference read with forwarding: port 0 first, then port 1, else stored.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (reg_write0 && write_reg0 == a) return write_data0;
    if (reg_write1 && write_reg1 == a) return write_data1;
    return m_regs[a];
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic idle();
    reset = 0; reg_write0 = 0; reg_write1 = 0; rsv_en = 0;
    write_reg0 = 0; write_reg1 = 0; write_data0 = 0; write_data1 = 0;
    rsv_reg = 0; read_reg1 = 0; read_reg2 = 0;
  endtask

  // Advance one clock, applying the model's view of that edge beforehand.
  task automatic tick();
    bit nb [32];
    bit hit;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_busy[r] = 0; end
      m_err = 0;
    end else begin
      hit = (reg_write0 && write_reg0 == rsv_reg) || (reg_write1 && write_reg1 == rsv_reg);
      if (rsv_en && rsv_reg != 0 && m_busy[rsv_reg] && !hit) m_err = 1;
      for (int r = 1; r < 32; r++) begin
        nb[r] = m_busy[r];
        if (rsv_en && rsv_reg == r) nb[r] = 1;
        else if ((reg_write0 && write_reg0 == r) || (reg_write1 && write_reg1 == r)) nb[r] = 0;
      end
      for (int r = 1; r < 32; r++) m_busy[r] = nb[r];
      if (reg_write1 && write_reg1 != 0) m_regs[write_reg1] = write_data1;
      if (reg_write0 && write_reg0 != 0) m_regs[write_reg0] = write_data0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle(); reg_write0 = 1; write_reg0 = 5; write_data0 = 32'hDEADBEEF; tick();
    idle(); read_reg1 = 5; #1;
    checks++; if (read_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_r5 got %h exp %h", read_data1, 32'hDEADBEEF); end
    reset = 1; tick(); reset = 0; #1;
    checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h exp 0", read_data1); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", busy_count); end
    checks++; if (err_double_rsv !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_double_rsv); end
    $display("test_reset done");
  endtask

  task automatic test_r0();
    idle(); reg_write0 = 1; write_reg0 = 0; write_data0 = 32'h12345678;
    rsv_en = 1; rsv_reg = 0; #1;
    checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0", read_data1); end
    tick(); idle(); #1;
    checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp 0", read_data1); end
    checks++; if (read_busy1 !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", read_busy1); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL r0_count got %0d exp 0", busy_count); end
    checks++; if (err_double_rsv !== 1'b0) begin errors++; $display("FAIL r0_err got %b exp 0", err_double_rsv); end
    $display("test_r0 done");
  endtask

  task automatic test_collision();
    idle(); reg_write0 = 1; write_reg0 = 7; write_data0 = 32'hAAAA0000;
    reg_write1 = 1; write_reg1 = 7; write_data1 = 32'h5555FFFF; tick();
    idle(); read_reg1 = 7; #1;
    checks++; if (read_data1 !== 32'hAAAA0000) begin errors++; $display("FAIL collide_r7 got %h exp %h", read_data1, 32'hAAAA0000); end
    reg_write0 = 1; write_reg0 = 7; write_data0 = 32'h00007777;
    reg_write1 = 1; write_reg1 = 8; write_data1 = 32'h00008888; tick();
    idle(); read_reg1 = 7; read_reg2 = 8; #1;
    checks++; if (read_data1 !== 32'h00007777) begin errors++; $display("FAIL dual_r7 got %h exp %h", read_data1, 32'h00007777); end
    checks++; if (read_data2 !== 32'h00008888) begin errors++; $display("FAIL dual_r8 got %h exp %h", read_data2, 32'h00008888); end
    $display("test_collision done");
  endtask

  task automatic test_bypass();
    idle(); read_reg1 = 9; reg_write1 = 1; write_reg1 = 9; write_data1 = 32'h00000042; #1;
    checks++; if (read_data1 !== 32'h00000042) begin errors++; $display("FAIL bypass_p1 got %h exp 42", read_data1); end
    tick(); idle(); read_reg2 = 9;
    reg_write0 = 1; write_reg0 = 9; write_data0 = 32'h00000099;
    reg_write1 = 1; write_reg1 = 9; write_data1 = 32'h00000011; #1;
    checks++; if (read_data2 !== 32'h00000099) begin errors++; $display("FAIL bypass_prio got %h exp 99", read_data2); end
    tick(); idle(); read_reg1 = 9; #1;
    checks++; if (read_data1 !== 32'h00000099) begin errors++; $display("FAIL bypass_stored got %h exp 99", read_data1); end
    $display("test_bypass done");
  endtask

  task automatic test_scoreboard();
    idle(); rsv_en = 1; rsv_reg = 3; read_reg1 = 3; #1;
    checks++; if (read_busy1 !== 1'b0) begin errors++; $display("FAIL rsv_no_bypass got %b exp 0", read_busy1); end
    tick(); idle(); read_reg1 = 3; #1;
    checks++; if (read_busy1 !== 1'b1) begin errors++; $display("FAIL rsv_busy got %b exp 1", read_busy1); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL rsv_count got %0d exp 1", busy_count); end
    reg_write1 = 1; write_reg1 = 3; write_data1 = 32'h3; tick();
    idle(); read_reg1 = 3; #1;
    checks++; if (read_busy1 !== 1'b0) begin errors++; $display("FAIL wb_busy got %b exp 0", read_busy1); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL wb_count got %0d exp 0", busy_count); end
    rsv_en = 1; rsv_reg = 4; reg_write0 = 1; write_reg0 = 4; write_data0 = 32'h4; tick();
    idle(); read_reg2 = 4; #1;
    checks++; if (read_busy2 !== 1'b1) begin errors++; $display("FAIL rsv_wins got %b exp 1", read_busy2); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL rsv_wins_count got %0d exp 1", busy_count); end
    do_reset();
    $display("test_scoreboard done");
  endtask

  task automatic test_double_rsv();
    idle(); rsv_en = 1; rsv_reg = 10; tick(); #1;
    checks++; if (err_double_rsv !== 1'b0) begin errors++; $display("FAIL dbl_first got %b exp 0", err_double_rsv); end
    tick(); idle(); #1;
    checks++; if (err_double_rsv !== 1'b1) begin errors++; $display("FAIL dbl_second got %b exp 1", err_double_rsv); end
    reg_write0 = 1; write_reg0 = 10; write_data0 = 32'hA; tick(); idle(); read_reg1 = 10; #1;
    checks++; if (err_double_rsv !== 1'b1 || read_busy1 !== 1'b0) begin errors++; $display("FAIL dbl_sticky got err=%b busy=%b exp err=1 busy=0", err_double_rsv, read_busy1); end
    do_reset(); #1;
    checks++; if (err_double_rsv !== 1'b0) begin errors++; $display("FAIL dbl_reset got %b exp 0", err_double_rsv); end
    for (int r = 1; r < 32; r++) begin idle(); rsv_en = 1; rsv_reg = 5'(r); tick(); end
    idle(); #1;
    checks++; if (busy_count !== 6'd31) begin errors++; $display("FAIL all_busy got %0d exp 31", busy_count); end
    checks++; if (err_double_rsv !== 1'b0) begin errors++; $display("FAIL all_busy_err got %b exp 0", err_double_rsv); end
    do_reset();
    $display("test_double_rsv done");
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      idle();
      reset       = ($urandom_range(0, 63) == 0);
      reg_write0  = $urandom_range(0, 2) == 0;
      reg_write1  = $urandom_range(0, 2) == 0;
      rsv_en      = $urandom_range(0, 1) == 0;
      write_reg0  = 5'($urandom_range(0, 7));
      write_reg1  = 5'($urandom_range(0, 7));
      rsv_reg     = 5'($urandom_range(0, 7));
      read_reg1   = 5'($urandom_range(0, 7));
      read_reg2   = 5'($urandom_range(0, 31));
      write_data0 = $urandom;
      write_data1 = $urandom;
      #1;
      checks++; if (read_data1 !== exp_read(read_reg1)) begin errors++; $display("FAIL rnd_rd1 t=%0d got %h exp %h", t, read_data1, exp_read(read_reg1)); end
      checks++; if (read_data2 !== exp_read(read_reg2)) begin errors++; $display("FAIL rnd_rd2 t=%0d got %h exp %h", t, read_data2, exp_read(read_reg2)); end
      checks++; if (read_busy1 !== m_busy[read_reg1] || read_busy2 !== m_busy[read_reg2]) begin errors++; $display("FAIL rnd_busy t=%0d got %b%b exp %b%b", t, read_busy1, read_busy2, m_busy[read_reg1], m_busy[read_reg2]); end
      checks++; if (int'(busy_count) != exp_count()) begin errors++; $display("FAIL rnd_count t=%0d got %0d exp %0d", t, busy_count, exp_count()); end
      checks++; if (err_double_rsv !== m_err) begin errors++; $display("FAIL rnd_err t=%0d got %b exp %b", t, err_double_rsv, m_err); end
      $display("txn %0d rst=%b w0=%b@%0d w1=%b@%0d rsv=%b@%0d cnt=%0d err=%b", t, reset, reg_write0, write_reg0, reg_write1, write_reg1, rsv_en, rsv_reg, busy_count, err_double_rsv);
      tick();
    end
  endtask

  initial begin
    idle(); reset = 1; tick(); tick(); reset = 0;
    test_reset();
    test_r0();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_double_rsv();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
